// File: rtl/line_buffer_window.sv
// Sliding KxK window generator for a raster-order pixel stream. K-1 line buffers
// supply the upper rows of each new right-hand column of a shift-register window.
module line_buffer_window #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_WIDTH  = 17,
    parameter int IMG_HEIGHT = 17,
    parameter int KERNEL     = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                valid_in,
    input  logic signed [DATA_WIDTH-1:0]        data_in,
    output logic                                ready_in,
    input  logic                                ready_out,
    output logic                                valid_out,
    output logic [KERNEL*KERNEL*DATA_WIDTH-1:0] window_out
);
    localparam int CW  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int NLB = KERNEL - 1;

    typedef enum logic {S_FILL, S_STREAM} state_t;

    state_t                       state_q, state_d;
    logic [CW-1:0]                col_q, col_d;
    logic [RW-1:0]                row_q, row_d;
    logic                         valid_out_q, valid_out_d;
    logic signed [DATA_WIDTH-1:0] win_q [KERNEL][KERNEL];
    logic signed [DATA_WIDTH-1:0] win_d [KERNEL][KERNEL];
    logic signed [DATA_WIDTH-1:0] lb_mem_q [NLB][IMG_WIDTH];
    logic signed [DATA_WIDTH-1:0] lb_tap [NLB];
    logic signed [DATA_WIDTH-1:0] lb_wdata_d [NLB];
    logic signed [DATA_WIDTH-1:0] col_vec [KERNEL];
    logic                         accept;
    logic                         emit;
    logic                         col_last;
    logic                         row_last;

    assign ready_in  = !valid_out_q || ready_out;
    assign accept    = valid_in && ready_in;
    assign col_last  = (col_q == CW'(IMG_WIDTH - 1));
    assign row_last  = (row_q == RW'(IMG_HEIGHT - 1));
    // Only full-height windows that do not straddle a row edge are emitted.
    assign emit      = accept && (state_q == S_STREAM) && (col_q >= CW'(KERNEL - 1));
    assign valid_out = valid_out_q;

    // Line buffers are addressed by column: reading at col before the write returns
    // the pixel one row up, and each buffer cascades its old entry into the next.
    always_comb begin
        for (int i = 0; i < NLB; i++) begin
            lb_tap[i] = lb_mem_q[i][col_q];
        end
        lb_wdata_d[0] = data_in;
        for (int i = 1; i < NLB; i++) begin
            lb_wdata_d[i] = lb_tap[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < NLB; i++) begin
                lb_mem_q[i][col_q] <= lb_wdata_d[i];
            end
        end
    end

    // Row 0 of the column is the oldest line, the deepest buffer tap.
    always_comb begin
        for (int r = 0; r < NLB; r++) begin
            col_vec[r] = lb_tap[NLB-1-r];
        end
        col_vec[KERNEL-1] = data_in;
    end

    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < KERNEL; r++) begin
                for (int c = 0; c < KERNEL - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][KERNEL-1] = col_vec[r];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        valid_out_d = valid_out_q;
        if (accept) begin
            valid_out_d = emit;
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end else if (ready_out) begin
            valid_out_d = 1'b0;
        end
        case (state_q)
            S_FILL: begin
                if (accept && col_last && (row_q == RW'(KERNEL - 2))) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (accept && col_last && row_last) begin
                    state_d = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FILL;
            col_q       <= '0;
            row_q       <= '0;
            valid_out_q <= 1'b0;
            for (int r = 0; r < KERNEL; r++) begin
                for (int c = 0; c < KERNEL; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            valid_out_q <= valid_out_d;
            win_q       <= win_d;
        end
    end

    always_comb begin
        window_out = '0;
        for (int r = 0; r < KERNEL; r++) begin
            for (int c = 0; c < KERNEL; c++) begin
                window_out[(r*KERNEL+c)*DATA_WIDTH +: DATA_WIDTH] = win_q[r][c];
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_window.sv
// Directed bench for line_buffer_window: 17x17/K=4 streaming, stall, random gaps,
// back-to-back frames, mid-frame reset, and 5x5 frames with K=2 and K=3.
module tb_line_buffer_window;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int fbase [2];

    // 17x17, K=4
    logic               a_valid_in = 1'b0;
    logic signed [15:0] a_data_in = '0;
    logic               a_ready_in;
    logic               a_ready_out = 1'b1;
    logic               a_valid_out;
    logic [255:0]       a_win;

    // 5x5 sweep, shared stimulus
    logic               s_valid_in = 1'b0;
    logic signed [15:0] s_data_in = '0;
    logic               s_ready_out = 1'b1;
    logic               b_ready_in, b_valid_out, c_ready_in, c_valid_out;
    logic [63:0]        b_win;
    logic [143:0]       c_win;

    line_buffer_window #(.DATA_WIDTH(16), .IMG_WIDTH(17), .IMG_HEIGHT(17), .KERNEL(4)) u_a (
        .clk(clk), .rst_n(rst_n), .valid_in(a_valid_in), .data_in(a_data_in),
        .ready_in(a_ready_in), .ready_out(a_ready_out), .valid_out(a_valid_out),
        .window_out(a_win));

    line_buffer_window #(.DATA_WIDTH(16), .IMG_WIDTH(5), .IMG_HEIGHT(5), .KERNEL(2)) u_b (
        .clk(clk), .rst_n(rst_n), .valid_in(s_valid_in), .data_in(s_data_in),
        .ready_in(b_ready_in), .ready_out(s_ready_out), .valid_out(b_valid_out),
        .window_out(b_win));

    line_buffer_window #(.DATA_WIDTH(16), .IMG_WIDTH(5), .IMG_HEIGHT(5), .KERNEL(3)) u_c (
        .clk(clk), .rst_n(rst_n), .valid_in(s_valid_in), .data_in(s_data_in),
        .ready_in(c_ready_in), .ready_out(s_ready_out), .valid_out(c_valid_out),
        .window_out(c_win));

    task automatic check_eq(input string tag, input logic signed [63:0] got,
                            input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [63:0] a_elem(input int r, input int c);
        return 64'($signed(a_win[(r*4+c)*16 +: 16]));
    endfunction

    function automatic int a_pix_val(input int pix);
        if (pix >= 578) return 0;
        return fbase[pix/289] + pix % 289;
    endfunction

    // Window k of the stream: bottom-right at (3 + idx/14, 3 + idx%14) of frame k/196.
    task automatic check_a_window(input string tag, input int k);
        int f, idx, br_r, br_c;
        f    = k / 196;
        idx  = k % 196;
        br_r = 3 + idx / 14;
        br_c = 3 + idx % 14;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                check_eq(tag, a_elem(r, c),
                         64'(fbase[f % 2] + (br_r - 3 + r) * 17 + (br_c - 3 + c)));
            end
        end
    endtask

    task automatic run_a(input int nframes, input bit rnd, input int stall_k,
                         input int pix_limit, input bit first_checks);
        int  pix = 0, k = 0, stall_left = 0, total, exp_win, limit;
        bit  stall_done = 0, first_seen = 0, done = 0;
        total   = nframes * 289;
        exp_win = nframes * 196;
        limit   = (pix_limit > 0) ? pix_limit : total;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk);
            if ((pix_limit > 0) ? (pix >= limit) : (pix >= total && k >= exp_win)) begin
                done = 1;
                break;
            end
            a_valid_in = (pix < limit) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
            a_data_in  = 16'(a_pix_val(pix));
            if (stall_left == 0 && !stall_done && stall_k >= 0 && a_valid_out && k == stall_k) begin
                stall_left = 5;
                stall_done = 1;
            end
            a_ready_out = (stall_left > 0) ? 1'b0 : (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
            #1;
            if (stall_left > 0) begin
                check_eq("stall_vo", 64'(a_valid_out), 1);
                check_eq("stall_rdy", 64'(a_ready_in), 0);
                check_a_window("stall_win", k);
                stall_left--;
            end
            if (first_checks && a_valid_out && !first_seen) begin
                first_seen = 1;
                check_eq("first_lat", pix, 55);
            end
            if (a_valid_out && a_ready_out) begin
                check_a_window("win", k);
                if (first_checks && k == 0) begin
                    check_eq("w0_00", a_elem(0, 0), 0);
                    check_eq("w0_03", a_elem(0, 3), 3);
                    check_eq("w0_30", a_elem(3, 0), 51);
                    check_eq("w0_33", a_elem(3, 3), 54);
                end
                if (first_checks && k == 195) check_eq("wlast_33", a_elem(3, 3), 288);
                k++;
            end
            if (a_valid_in && a_ready_in) pix++;
        end
        a_valid_in  = 1'b0;
        a_ready_out = 1'b1;
        check_eq("run_done", 64'(done), 1);
        if (pix_limit == 0) begin
            #1;
            check_eq("win_count", k, exp_win);
            check_eq("idle_vo", 64'(a_valid_out), 0);
        end
    endtask

    function automatic int sm_exp(input int kk, input int k, input int r, input int c);
        int wn, br_r, br_c;
        wn   = 6 - kk;
        br_r = kk - 1 + k / wn;
        br_c = kk - 1 + k % wn;
        return (br_r - kk + 1 + r) * 5 + (br_c - kk + 1 + c);
    endfunction

    initial begin
        int pb, kb, kc;
        fbase[0] = 0;
        fbase[1] = 1000;

        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_vo", 64'(a_valid_out), 0);
        check_eq("rst_win", 64'(a_win == '0), 1);
        check_eq("rst_rdy", 64'(a_ready_in), 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_rdy", 64'(a_ready_in), 1);

        run_a(1, 0, -1, 0, 1);
        run_a(1, 0, 10, 0, 0);
        run_a(1, 1, -1, 0, 0);
        run_a(2, 0, -1, 0, 0);

        // Abandon a frame after 100 pixels, then stream a fresh one.
        run_a(1, 0, -1, 100, 0);
        a_ready_out = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_vo", 64'(a_valid_out), 0);
        check_eq("mid_rst_rdy", 64'(a_ready_in), 1);
        check_eq("mid_rst_win", 64'(a_win == '0), 1);
        a_ready_out = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_a(1, 0, -1, 0, 0);

        pb = 0;
        kb = 0;
        kc = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            s_valid_in = (pb < 25);
            s_data_in  = 16'(pb);
            #1;
            check_eq("c_rdy", 64'(c_ready_in), 1);
            if (b_valid_out) begin
                for (int r = 0; r < 2; r++)
                    for (int c = 0; c < 2; c++)
                        check_eq("k2_win", 64'($signed(b_win[(r*2+c)*16 +: 16])), 64'(sm_exp(2, kb, r, c)));
                kb++;
            end
            if (c_valid_out) begin
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        check_eq("k3_win", 64'($signed(c_win[(r*3+c)*16 +: 16])), 64'(sm_exp(3, kc, r, c)));
                kc++;
            end
            if (s_valid_in && b_ready_in) pb++;
        end
        s_valid_in = 1'b0;
        check_eq("k2_count", kb, 16);
        check_eq("k3_count", kc, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/line_buffer_window.md
LINE_BUFFER_WINDOW -- requirements
Module: line_buffer_window

Parameters
REQ-001 DATA_WIDTH, 16, width of one signed pixel.
REQ-002 IMG_WIDTH, 17, width of the padded input frame in pixels, equal to the upstream pad-stage total width.
REQ-003 IMG_HEIGHT, 17, height of the padded input frame in rows.
REQ-004 KERNEL, 4, window edge K; the block SHALL be legal for 2 <= K <= min(IMG_WIDTH, IMG_HEIGHT).

Interface
REQ-005 clk  input  1  single clock, all logic rising-edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 valid_in  input  1  upstream pixel valid.
REQ-008 data_in  input  DATA_WIDTH signed  raster-order pixel, row-major, left to right.
REQ-009 ready_in  output  1  block accepts data_in this cycle.
REQ-010 ready_out  input  1  downstream consumer (conv MAC) accepts the window.
REQ-011 valid_out  output  1  window_out holds a valid KxK window.
REQ-012 window_out  output  K*K*DATA_WIDTH  flattened window; element (r,c) at bits [(r*K+c)*DATA_WIDTH +: DATA_WIDTH]; r=0 is the oldest (top) row, c=0 the leftmost column.

Function
REQ-013 Storage: K-1 line buffers, each IMG_WIDTH deep, plus a KxK register window; no other pixel storage.
REQ-014 ready_in = !valid_out || ready_out, combinational; an accept is valid_in && ready_in.
REQ-015 On each accept, column c of the window shifts left by one, the new right column is {line buffer taps, data_in} vertically aligned for the current column, and the line buffers shift by one entry.
REQ-016 Counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) track the position of the accepted pixel; col wraps to 0 and row increments at col==IMG_WIDTH-1.
REQ-017 FSM states: S_FILL (row < K-1, no output) and S_STREAM (row >= K-1); S_FILL->S_STREAM on accepting pixel (K-2, IMG_WIDTH-1); S_STREAM->S_FILL on accepting pixel (IMG_HEIGHT-1, IMG_WIDTH-1), with row and col cleared to 0.
REQ-018 A window is emitted when the accepted pixel has row >= K-1 and col >= K-1; valid_out rises on the next clock edge (latency 1), and window_out bottom-right equals that pixel.
REQ-019 Windows per frame = (IMG_HEIGHT-K+1)*(IMG_WIDTH-K+1), in raster order of their bottom-right pixel; no window straddles a row or frame boundary.
REQ-020 Backpressure: while valid_out && !ready_out, window_out, valid_out, counters, state and line buffers SHALL hold unchanged, and ready_in is 0.
REQ-021 When valid_out && ready_out with no new emitting accept, valid_out falls next cycle; an emitting accept in the same cycle as a consume SHALL produce back-to-back windows with no bubble.
REQ-022 Back-to-back frames: the first pixel of frame N+1 may be accepted the cycle after the last pixel of frame N; stale line-buffer contents are never emitted, because of the S_FILL gating.
REQ-023 Pixels pass through unmodified, signed, with no arithmetic or saturation.

Reset
REQ-024 On rst_n low, asynchronously: valid_out=0, window_out=0, row=0, col=0, state=S_FILL; line-buffer contents need not be cleared.
REQ-025 Reset mid-frame SHALL abandon the partial frame; the first accept after reset release is treated as pixel (0,0).
REQ-026 ready_in SHALL be 1 during and immediately after reset (valid_out=0).

Verification
REQ-027 Defaults (17x17, K=4), pixel value = row*17+col, valid_in always 1, ready_out always 1 -> first valid_out one cycle after pixel 54 accepted; window (0,0)=0, (0,3)=3, (3,0)=51, (3,3)=54; exactly 196 windows; last window bottom-right=288.
REQ-028 Same stimulus with ready_out low for 5 cycles at window 10 -> window_out stable for all 5 cycles, ready_in=0, no window lost or duplicated, total still 196.
REQ-029 Random valid_in gaps (50%) and random ready_out (50%) -> output window sequence identical to REQ-027.
REQ-030 Two consecutive frames, second with value = 1000+row*17+col -> 392 windows; first window of frame 2 has (0,0)=1000, and no window mixes frame-1 and frame-2 values.
REQ-031 rst_n pulsed low after 100 accepted pixels, then a fresh frame -> valid_out=0 immediately; the fresh frame yields exactly 196 correct windows.
REQ-032 Parameter sweep K=2 and K=3 on a 5x5 frame -> 16 and 9 windows respectively, contents matching a reference model.
